// File: rtl/code_entry.sv
// Keypad credential entry front end: collects four username digits followed by
// four password digits. It clears itself on the unlocker's reset_count, on a
// user clear, or after TIMEOUT_CYCLES idle cycles with a partial entry.
//
// state   | meaning
// EMPTY   | no digits entered (count 0)
// USER    | filling username slots (count 1..3)
// PASS    | filling password slots (count 4..7)
// FULL    | all eight digits held, waiting to be consumed (count 8)
module code_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_digit_valid,
  input  logic [3:0] i_digit,
  input  logic       i_backspace,
  input  logic       i_clear,
  input  logic       i_reset_count,
  output logic [3:0] o_input_count,
  output logic [3:0] o_user_name_input0,
  output logic [3:0] o_user_name_input1,
  output logic [3:0] o_user_name_input2,
  output logic [3:0] o_user_name_input3,
  output logic [3:0] o_password_input0,
  output logic [3:0] o_password_input1,
  output logic [3:0] o_password_input2,
  output logic [3:0] o_password_input3,
  output logic       o_entry_done,
  output logic       o_digit_error,
  output logic       o_timed_out
);

  typedef enum logic [1:0] {S_EMPTY, S_USER, S_PASS, S_FULL} state_t;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic state_t state_of(input logic [3:0] cnt);
    if (cnt == 4'd0)      return S_EMPTY;
    else if (cnt < 4'd4)  return S_USER;
    else if (cnt < 4'd8)  return S_PASS;
    else                  return S_FULL;
  endfunction

  state_t      r_state;
  logic [3:0]  r_count;
  logic [3:0]  r_slot [8];
  logic [15:0] r_idle;
  logic        r_entry_done;
  logic        r_digit_error;
  logic        r_timed_out;

  logic        w_any_strobe;
  logic        w_partial;
  logic        w_flush;
  logic        w_timeout;
  logic        w_do_bs;
  logic        w_try_digit;
  logic        w_do_digit;
  logic        w_reject;
  logic [2:0]  w_bs_idx;
  logic [2:0]  w_wr_idx;
  logic [3:0]  w_count_next;

  assign w_any_strobe = i_digit_valid | i_backspace | i_clear | i_reset_count;
  assign w_partial    = (r_state == S_USER) || (r_state == S_PASS);
  assign w_flush      = i_reset_count | i_clear;
  // Any strobe reloads the idle counter, so the timeout only fires on a quiet cycle.
  assign w_timeout    = w_partial && !w_any_strobe && (r_idle == IDLE_LAST);
  assign w_do_bs      = !w_flush && i_backspace && (r_state != S_EMPTY);
  // A backspace in the same cycle swallows the keypress silently.
  assign w_try_digit  = !w_flush && !i_backspace && i_digit_valid;
  assign w_do_digit   = w_try_digit && (i_digit <= 4'd9) && (r_state != S_FULL);
  assign w_reject     = w_try_digit && !w_do_digit;
  // At count 8 the low bits are 0, so the wrap to 7 selects the last slot.
  assign w_bs_idx     = r_count[2:0] - 3'd1;
  assign w_wr_idx     = r_count[2:0];

  // Next digit count from the prioritised event set.
  always_comb begin
    w_count_next = r_count;
    if (w_flush || w_timeout) w_count_next = 4'd0;
    else if (w_do_bs)         w_count_next = r_count - 4'd1;
    else if (w_do_digit)      w_count_next = r_count + 4'd1;
  end

  // Entry FSM: count, state, slots, idle timer and pulse outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_EMPTY;
      r_count       <= 4'd0;
      r_idle        <= 16'd0;
      r_entry_done  <= 1'b0;
      r_digit_error <= 1'b0;
      r_timed_out   <= 1'b0;
      for (int k = 0; k < 8; k++) r_slot[k] <= 4'd0;
    end else begin
      r_count       <= w_count_next;
      r_state       <= state_of(w_count_next);
      r_entry_done  <= w_do_digit && (r_count == 4'd7);
      r_digit_error <= w_reject;
      r_timed_out   <= w_timeout;
      if (w_any_strobe || !w_partial || w_timeout) r_idle <= 16'd0;
      else                                         r_idle <= r_idle + 16'd1;
      if (w_flush || w_timeout) begin
        for (int k = 0; k < 8; k++) r_slot[k] <= 4'd0;
      end else if (w_do_bs) begin
        r_slot[w_bs_idx] <= 4'd0;
      end else if (w_do_digit) begin
        r_slot[w_wr_idx] <= i_digit;
      end
    end
  end

  assign o_input_count      = r_count;
  assign o_user_name_input0 = r_slot[0];
  assign o_user_name_input1 = r_slot[1];
  assign o_user_name_input2 = r_slot[2];
  assign o_user_name_input3 = r_slot[3];
  assign o_password_input0  = r_slot[4];
  assign o_password_input1  = r_slot[5];
  assign o_password_input2  = r_slot[6];
  assign o_password_input3  = r_slot[7];
  assign o_entry_done       = r_entry_done;
  assign o_digit_error      = r_digit_error;
  assign o_timed_out        = r_timed_out;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry. The driver pushes the hand-computed result of
// each cycle into a queue; a monitor on the falling edge pops and compares.
// Slot expectations are written as 32-bit hex, slot 0 in the leftmost nibble.
module tb_code_entry;

  logic       clk;
  logic       i_reset, i_digit_valid, i_backspace, i_clear, i_reset_count;
  logic [3:0] i_digit;
  logic [3:0] o_input_count;
  logic [3:0] u0, u1, u2, u3, p0, p1, p2, p3;
  logic       o_entry_done, o_digit_error, o_timed_out;

  code_entry #(.TIMEOUT_CYCLES(10)) dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .i_digit_valid     (i_digit_valid),
    .i_digit           (i_digit),
    .i_backspace       (i_backspace),
    .i_clear           (i_clear),
    .i_reset_count     (i_reset_count),
    .o_input_count     (o_input_count),
    .o_user_name_input0(u0),
    .o_user_name_input1(u1),
    .o_user_name_input2(u2),
    .o_user_name_input3(u3),
    .o_password_input0 (p0),
    .o_password_input1 (p1),
    .o_password_input2 (p2),
    .o_password_input3 (p3),
    .o_entry_done      (o_entry_done),
    .o_digit_error     (o_digit_error),
    .o_timed_out       (o_timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  cnt;
    logic [31:0] slots;
    logic        done;
    logic        err;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [31:0] act_slots = {u0, u1, u2, u3, p0, p1, p2, p3};

  // Monitor: one expectation per clock, checked away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (o_input_count !== e.cnt || act_slots !== e.slots || o_entry_done !== e.done ||
          o_digit_error !== e.err || o_timed_out !== e.to) begin
        n_bad++;
        $display("FAIL %s: got cnt=%0d slots=%h done=%b err=%b to=%b, expected cnt=%0d slots=%h done=%b err=%b to=%b",
                 e.tag, o_input_count, act_slots, o_entry_done, o_digit_error, o_timed_out,
                 e.cnt, e.slots, e.done, e.err, e.to);
      end
    end
  end

  task automatic step(input string tag, input logic rst, input logic dv, input logic [3:0] d,
                      input logic bs, input logic clr, input logic rc,
                      input logic [3:0] ec, input logic [31:0] es,
                      input logic ed, input logic ee, input logic et);
    exp_t e;
    i_reset = rst; i_digit_valid = dv; i_digit = d;
    i_backspace = bs; i_clear = clr; i_reset_count = rc;
    e.tag = tag; e.cnt = ec; e.slots = es; e.done = ed; e.err = ee; e.to = et;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic key(input string tag, input logic [3:0] d,
                     input logic [3:0] ec, input logic [31:0] es, input logic ed, input logic ee);
    step(tag, 0, 1, d, 0, 0, 0, ec, es, ed, ee, 0);
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] ec, input logic [31:0] es);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 4'd0, 0, 0, 0, ec, es, 0, 0, 0);
  endtask

  initial begin
    i_reset = 1; i_digit_valid = 0; i_digit = 0;
    i_backspace = 0; i_clear = 0; i_reset_count = 0;

    step("reset", 1, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0, 0, 0, 0);

    // Full entry 0,0,1,1,0,0,1,1
    key("fill1", 4'd0, 4'd1, 32'h0000_0000, 0, 0);
    key("fill2", 4'd0, 4'd2, 32'h0000_0000, 0, 0);
    key("fill3", 4'd1, 4'd3, 32'h0010_0000, 0, 0);
    key("fill4", 4'd1, 4'd4, 32'h0011_0000, 0, 0);
    key("fill5", 4'd0, 4'd5, 32'h0011_0000, 0, 0);
    key("fill6", 4'd0, 4'd6, 32'h0011_0000, 0, 0);
    key("fill7", 4'd1, 4'd7, 32'h0011_0010, 0, 0);
    key("fill8", 4'd1, 4'd8, 32'h0011_0011, 1, 0);

    idle("full_idle", 50, 4'd8, 32'h0011_0011);
    key("ninth_digit", 4'd5, 4'd8, 32'h0011_0011, 0, 1);

    step("bs_from_full", 0, 0, 4'd0, 1, 0, 0, 4'd7, 32'h0011_0010, 0, 0, 0);
    key("refill8", 4'd1, 4'd8, 32'h0011_0011, 1, 0);

    step("reset_count_drop_dv", 0, 1, 4'd4, 0, 0, 1, 4'd0, 32'h0, 0, 0, 0);
    step("bs_at_empty", 0, 0, 4'd0, 1, 0, 0, 4'd0, 32'h0, 0, 0, 0);

    key("d1", 4'd1, 4'd1, 32'h1000_0000, 0, 0);
    key("d2", 4'd2, 4'd2, 32'h1200_0000, 0, 0);
    key("d3", 4'd3, 4'd3, 32'h1230_0000, 0, 0);
    step("bs_3to2", 0, 0, 4'd0, 1, 0, 0, 4'd2, 32'h1200_0000, 0, 0, 0);
    key("d5", 4'd5, 4'd3, 32'h1250_0000, 0, 0);
    step("bs_again", 0, 0, 4'd0, 1, 0, 0, 4'd2, 32'h1200_0000, 0, 0, 0);
    key("digit12", 4'hC, 4'd2, 32'h1200_0000, 0, 1);
    step("clear", 0, 0, 4'd0, 0, 1, 0, 4'd0, 32'h0, 0, 0, 0);

    // Timeout: 10 cycles after the last strobe
    key("t_d7", 4'd7, 4'd1, 32'h7000_0000, 0, 0);
    key("t_d8", 4'd8, 4'd2, 32'h7800_0000, 0, 0);
    idle("t_wait", 9, 4'd2, 32'h7800_0000);
    step("timeout", 0, 0, 4'd0, 0, 0, 0, 4'd0, 32'h0, 0, 0, 1);
    idle("after_timeout", 3, 4'd0, 32'h0);

    key("bd_d3", 4'd3, 4'd1, 32'h3000_0000, 0, 0);
    step("bs_with_dv", 0, 1, 4'd6, 1, 0, 0, 4'd0, 32'h0, 0, 0, 0);

    key("r1", 4'd1, 4'd1, 32'h1000_0000, 0, 0);
    key("r2", 4'd2, 4'd2, 32'h1200_0000, 0, 0);
    key("r3", 4'd3, 4'd3, 32'h1230_0000, 0, 0);
    key("r4", 4'd4, 4'd4, 32'h1234_0000, 0, 0);
    key("r5", 4'd5, 4'd5, 32'h1234_5000, 0, 0);
    step("reset_mid", 1, 1, 4'd9, 0, 0, 0, 4'd0, 32'h0, 0, 0, 0);
    key("after_reset_d7", 4'd7, 4'd1, 32'h7000_0000, 0, 0);
    idle("tail", 2, 4'd1, 32'h7000_0000);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_entry.md
Name: code_entry

Overview:
- Keypad-side front end that produces the credential bus consumed by the unlocker.
- Accepts single-cycle digit keypresses from the debounced keypad. Fills four username slots, then four password slots.
- Drives inputCount and the eight digit registers. Clears itself on the unlocker's resetCount, on a user clear, or on an inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles with a partial entry (count 1..7) before auto-clear. Legal range 1..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- digitValid  input  1  one-cycle strobe; digit is valid this cycle
- digit  input  4  keypad value; legal values 0..9
- backspace  input  1  one-cycle strobe; removes the last digit
- clear  input  1  one-cycle strobe; discards the whole entry
- resetCount  input  1  from the unlocker; entry consumed or rejected, restart at 0
- inputCount  output  4  number of digits entered, 0..8
- userNameInput0..3  output  4 each  username digits, slot 0 first
- passwordInput0..3  output  4 each  password digits, slot 0 first
- entryDone  output  1  one-cycle pulse when inputCount becomes 8
- digitError  output  1  one-cycle pulse when a keypress is rejected
- timedOut  output  1  one-cycle pulse when the timeout clear fires

Behaviour:
- All outputs are registered. On reset: inputCount=0, all eight digit registers=0, entryDone=0, digitError=0, timedOut=0, idle counter=0.
- State is derived from inputCount:
  - EMPTY (0)
  - USER (1..3)
  - PASS (4..7)
  - FULL (8)
- Accepted digit: digitValid=1, digit<=9, count<8.
  - The digit is written to slot[count]. Slots 0..3 are userNameInput0..3; slots 4..7 are passwordInput0..3.
  - count increments by 1.
  - Both updates are visible the cycle after the strobe (latency 1).
- Rejected digit: digitValid with digit>9, or with count==8.
  - No change to count or slots.
  - digitError pulses for 1 cycle.
- Backspace with count>0:
  - count decrements by 1.
  - slot[count-1] is cleared to 0.
- Backspace with count==0: ignored, no error pulse.
- entryDone pulses on the cycle inputCount transitions 7->8, and only then.
- FULL holds all values stable until resetCount, clear or reset. Backspace in FULL is permitted and returns to count 7.
- resetCount or clear: count=0 and all slots=0 on the next cycle.
- Idle counter:
  - Increments each cycle while 1<=count<=7 and no strobe is present.
  - Reloads to 0 on any strobe (digitValid, backspace, clear, resetCount).
  - Held at 0 when count is 0 or 8.
- Timeout: when the idle counter reaches TIMEOUT_CYCLES-1 and would increment, perform the clear action and pulse timedOut for 1 cycle.
- Priority when events coincide in the same cycle (highest first): reset > resetCount > clear > timeout > backspace > digitValid.
  - A lower-priority event in the same cycle is dropped, with no error pulse.
  - Example: backspace together with digitValid removes one digit and stores nothing.
- Slot values above the current count are always 0.
- Reset in the middle of an entry takes effect in that cycle's update, regardless of state.
- inputCount never exceeds 8 and never wraps below 0.

Test Plan:
- Reset, then strobe digits 0,0,1,1,0,0,1,1 on consecutive cycles:
  - inputCount steps 1..8.
  - userNameInput0..3 = 0,0,1,1 and passwordInput0..3 = 0,0,1,1.
  - entryDone is high exactly on the cycle count becomes 8.
- Strobe digits 1,2,3, then backspace, then 5:
  - Count goes 3 -> 2 -> 3.
  - userNameInput2 = 5 and userNameInput3 = 0.
- Digit 12 at count 2: digitError pulses, count stays 2. A 9th digit at count 8: digitError pulses, all slots unchanged.
- TIMEOUT_CYCLES=10, strobe two digits, then idle:
  - timedOut pulses 10 cycles after the last strobe.
  - Count and all slots return to 0.
  - With count at 8 and idle for 50 cycles, no timeout occurs.
- At count 8, assert resetCount: next cycle count=0 and all slots=0. A simultaneous digitValid is dropped.
- Assert reset at count 5 together with digitValid: next cycle all outputs=0. A following digit 7 lands in userNameInput0.
